// File: rtl/uart_pkg.sv
// Shared UART types, legal parameter ranges and the parity helper.
// Latency: none (types and functions only).
// Backpressure: not applicable.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

    localparam int DATA_BITS_MIN = 5;
    localparam int DATA_BITS_MAX = 9;
    localparam int STOP_BITS_MIN = 1;
    localparam int STOP_BITS_MAX = 2;

    // Even parity is the XOR of all data bits; odd parity is its inverse.
    // Callers zero-extend narrower words, which leaves the XOR unchanged.
    function automatic logic uart_parity(input logic [DATA_BITS_MAX-1:0] data,
                                         input logic                     odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Baud divider: pulses bit_end in the last clk of every serial bit period.
// Latency: bit_end in the CLKS_PER_BIT-th enabled cycle, then every CLKS_PER_BIT cycles.
// Backpressure: none; the counter is held at zero whenever enable is low.
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    output logic bit_end
);

    localparam int                CW       = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]     CNT_LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q;

    // Count 0..CLKS_PER_BIT-1 while enabled, wrap at terminal count, park at 0 otherwise.
    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            cnt_q <= '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign bit_end = enable && (cnt_q == CNT_LAST);

endmodule

// File: rtl/uart_tx_core.sv
// UART transmitter: start bit, DATA_BITS data bits LSB first, optional parity, 1-2 stop bits.
// Latency: start bit on tx the cycle after the handshake; frame is (1+DATA_BITS+PARITY_EN+STOP_BITS)*CLKS_PER_BIT cycles.
// Backpressure: tx_ready low while a frame is in flight, high again in its final cycle so frames can run back to back.
module uart_tx_core
    import uart_pkg::*;
#(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 1,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tx_valid,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 busy,
    output logic                 tx_done
);

    // Reject illegal configurations while elaborating.
    if (DATA_BITS < DATA_BITS_MIN || DATA_BITS > DATA_BITS_MAX) begin : g_bad_data_bits
        $error("uart_tx_core: DATA_BITS must be 5..9");
    end
    if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
        $error("uart_tx_core: CLKS_PER_BIT must be >= 2");
    end
    if (PARITY_EN != 0 && PARITY_EN != 1) begin : g_bad_parity_en
        $error("uart_tx_core: PARITY_EN must be 0 or 1");
    end
    if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity_odd
        $error("uart_tx_core: PARITY_ODD must be 0 or 1");
    end
    if (STOP_BITS < STOP_BITS_MIN || STOP_BITS > STOP_BITS_MAX) begin : g_bad_stop_bits
        $error("uart_tx_core: STOP_BITS must be 1 or 2");
    end

    localparam int             BCW      = $clog2(DATA_BITS + 1);
    localparam logic [BCW-1:0] BIT_LAST = BCW'(DATA_BITS - 1);

    tx_state_e              state_q, state_d;
    logic [DATA_BITS-1:0]   shreg_q, shreg_d;
    logic [BCW-1:0]         bit_cnt_q, bit_cnt_d;
    logic                   stop_cnt_q, stop_cnt_d;
    logic                   par_q, par_d;
    logic                   tx_q, tx_d;
    logic                   bit_end;
    logic                   accept;
    logic [DATA_BITS_MAX-1:0] data_ext;
    logic                   par_in;

    // Bit timing: runs for the whole frame, frozen at zero while idle.
    uart_baud_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_gen (
        .clk     (clk),
        .reset   (reset),
        .enable  (state_q != IDLE),
        .bit_end (bit_end)
    );

    // Widen the incoming word so the shared parity helper sees a fixed width.
    always_comb begin
        data_ext                  = '0;
        data_ext[DATA_BITS-1:0]   = tx_data;
    end

    assign par_in = uart_parity(data_ext, PARITY_ODD != 0);

    // Frame sequencing, handshake and next value of the serial line.
    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        par_d      = par_q;
        tx_ready   = 1'b0;
        tx_done    = 1'b0;
        accept     = 1'b0;
        tx_d       = 1'b1;

        unique case (state_q)
            IDLE: begin
                tx_ready = 1'b1;
                accept   = tx_valid;
            end
            START: begin
                if (bit_end) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shreg_d = shreg_q >> 1;
                    if (bit_cnt_q == BIT_LAST) begin
                        state_d    = (PARITY_EN != 0) ? PARITY : STOP;
                        stop_cnt_d = 1'b0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BCW'(1);
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_d    = STOP;
                    stop_cnt_d = 1'b0;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (STOP_BITS == 2 && !stop_cnt_q) begin
                        stop_cnt_d = 1'b1;
                    end else begin
                        // Final cycle of the frame: a new word may be taken right here.
                        tx_done  = 1'b1;
                        tx_ready = 1'b1;
                        state_d  = IDLE;
                        accept   = tx_valid;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Parity is frozen with the word, so later tx_data changes cannot leak in.
        if (accept) begin
            state_d = START;
            shreg_d = tx_data;
            par_d   = par_in;
        end

        unique case (state_d)
            IDLE:    tx_d = 1'b1;
            START:   tx_d = 1'b0;
            DATA:    tx_d = shreg_d[0];
            PARITY:  tx_d = par_d;
            default: tx_d = 1'b1;
        endcase
    end

    // State, datapath and registered serial output.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            par_q      <= 1'b0;
            tx_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            par_q      <= par_d;
            tx_q       <= tx_d;
        end
    end

    assign tx   = tx_q;
    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_core.sv
// Bench for uart_tx_core: three configurations checked cycle by cycle against a frame-level model.
// Latency: not applicable.
// Backpressure: not applicable.
module tb_uart_tx_core;

    logic       clk = 1'b0;
    logic       reset;
    logic       vld;
    logic [8:0] din;
    int         sel;

    logic tx_a, rdy_a, busy_a, done_a;
    logic tx_b, rdy_b, busy_b, done_b;
    logic tx_c, rdy_c, busy_c, done_c;
    logic obs_tx, obs_rdy, obs_busy, obs_done;

    int n_assert = 0;
    int n_fail   = 0;

    // Per-configuration frame rules: data bits, clocks per bit, parity enable, odd parity, stop bits.
    int cfg_db  [3] = '{8, 8, 7};
    int cfg_cpb [3] = '{16, 4, 4};
    int cfg_pe  [3] = '{1, 1, 0};
    int cfg_po  [3] = '{0, 1, 0};
    int cfg_sb  [3] = '{1, 1, 2};

    always #5 clk = ~clk;

    uart_tx_core #(.DATA_BITS(8), .CLKS_PER_BIT(16), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_dut_a (
        .clk(clk), .reset(reset), .tx_valid(vld && sel == 0), .tx_data(din[7:0]),
        .tx_ready(rdy_a), .tx(tx_a), .busy(busy_a), .tx_done(done_a));

    uart_tx_core #(.DATA_BITS(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_dut_b (
        .clk(clk), .reset(reset), .tx_valid(vld && sel == 1), .tx_data(din[7:0]),
        .tx_ready(rdy_b), .tx(tx_b), .busy(busy_b), .tx_done(done_b));

    uart_tx_core #(.DATA_BITS(7), .CLKS_PER_BIT(4), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u_dut_c (
        .clk(clk), .reset(reset), .tx_valid(vld && sel == 2), .tx_data(din[6:0]),
        .tx_ready(rdy_c), .tx(tx_c), .busy(busy_c), .tx_done(done_c));

    always_comb begin
        case (sel)
            0:       {obs_tx, obs_rdy, obs_busy, obs_done} = {tx_a, rdy_a, busy_a, done_a};
            1:       {obs_tx, obs_rdy, obs_busy, obs_done} = {tx_b, rdy_b, busy_b, done_b};
            default: {obs_tx, obs_rdy, obs_busy, obs_done} = {tx_c, rdy_c, busy_c, done_c};
        endcase
    end

    function automatic int frame_len(input int s);
        return (1 + cfg_db[s] + cfg_pe[s] + cfg_sb[s]) * cfg_cpb[s];
    endfunction

    // Line level during bit period b of a frame carrying word d.
    function automatic logic exp_level(input int s, input int d, input int b);
        int db = cfg_db[s];
        int w  = d & ((1 << db) - 1);
        if (b == 0) return 1'b0;
        if (b <= db) return 1'((w >> (b - 1)) & 1);
        if (cfg_pe[s] != 0 && b == db + 1) return 1'(($countones(w) % 2) ^ cfg_po[s]);
        return 1'b1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sel_dut(input int s);
        sel = s;
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present a word on an idle core and complete the handshake edge.
    task automatic start(input int s, input int d);
        vld = 1'b1;
        din = 9'(d);
        chk("ready_before_accept", 32'(obs_rdy), 32'd1);
        step();
    endtask

    // Check every cycle of a frame; optionally chain the next word or stop early at abort_at.
    task automatic run_frame(input int s, input int d, input int hold,
                             input int next_v, input int next_d, input int abort_at);
        int f = frame_len(s);
        for (int k = 1; k <= f; k++) begin
            chk("tx_bit",  32'(obs_tx),   32'(exp_level(s, d, (k - 1) / cfg_cpb[s])));
            chk("busy",    32'(obs_busy), 32'd1);
            chk("tx_done", 32'(obs_done), 32'(k == f));
            chk("ready",   32'(obs_rdy),  32'(k == f));
            if (abort_at != 0 && k == abort_at) return;
            if (k == f) begin
                vld = 1'(next_v);
                din = 9'(next_d);
            end else if (hold != 0) begin
                vld = 1'b1;
                din = 9'($urandom);
            end else begin
                vld = 1'b0;
            end
            step();
        end
    endtask

    task automatic idle_check(input int n);
        for (int i = 0; i < n; i++) begin
            chk("idle_tx",   32'(obs_tx),   32'd1);
            chk("idle_busy", 32'(obs_busy), 32'd0);
            chk("idle_rdy",  32'(obs_rdy),  32'd1);
            chk("idle_done", 32'(obs_done), 32'd0);
            step();
        end
    endtask

    initial begin
        int w [4];
        reset = 1'b1;
        vld   = 1'b0;
        din   = '0;
        sel   = 0;
        repeat (3) step();

        // Reset state of all three configurations.
        for (int s = 0; s < 3; s++) begin
            sel_dut(s);
            chk("rst_tx",   32'(obs_tx),   32'd1);
            chk("rst_rdy",  32'(obs_rdy),  32'd1);
            chk("rst_busy", 32'(obs_busy), 32'd0);
            chk("rst_done", 32'(obs_done), 32'd0);
        end
        reset = 1'b0;
        step();

        // Default frame with 0xA5, then idle with tx_valid low.
        sel_dut(0);
        idle_check(3);
        start(0, 'hA5);
        run_frame(0, 'hA5, 0, 0, 0, 0);
        idle_check(5);

        // Odd parity on 0x00 and 0x01.
        sel_dut(1);
        start(1, 'h00);
        run_frame(1, 'h00, 0, 0, 0, 0);
        idle_check(2);
        start(1, 'h01);
        run_frame(1, 'h01, 0, 0, 0, 0);
        idle_check(2);

        // Back-to-back 0x55 then 0x0F with no idle gap.
        sel_dut(0);
        start(0, 'h55);
        run_frame(0, 'h55, 0, 1, 'h0F, 0);
        run_frame(0, 'h0F, 0, 0, 0, 0);
        idle_check(3);

        // Seven data bits, no parity, two stop bits, 0x7F.
        sel_dut(2);
        start(2, 'h7F);
        run_frame(2, 'h7F, 0, 0, 0, 0);
        idle_check(3);

        // Reset during data bit 3 of 0xF0, then a clean frame.
        sel_dut(0);
        start(0, 'hF0);
        run_frame(0, 'hF0, 0, 0, 0, 4 * 16 + 8);
        reset = 1'b1;
        vld   = 1'b0;
        step();
        reset = 1'b0;
        chk("abort_tx",   32'(obs_tx),   32'd1);
        chk("abort_rdy",  32'(obs_rdy),  32'd1);
        chk("abort_busy", 32'(obs_busy), 32'd0);
        chk("abort_done", 32'(obs_done), 32'd0);
        idle_check(20);
        start(0, 'hF0);
        run_frame(0, 'hF0, 0, 0, 0, 0);
        idle_check(2);

        // tx_valid held through the frame with churning tx_data: exactly one frame.
        w[0] = int'($urandom_range(0, 255));
        start(0, w[0]);
        run_frame(0, w[0], 1, 0, 0, 0);
        idle_check(20);

        // Random words: singles on the odd-parity core, a chain on the 7-bit core.
        sel_dut(1);
        for (int i = 0; i < 3; i++) begin
            w[0] = int'($urandom_range(0, 255));
            start(1, w[0]);
            run_frame(1, w[0], 0, 0, 0, 0);
            idle_check(1);
        end
        sel_dut(2);
        for (int i = 0; i < 4; i++) w[i] = int'($urandom_range(0, 127));
        start(2, w[0]);
        for (int i = 0; i < 4; i++) begin
            run_frame(2, w[i], 0, (i < 3) ? 1 : 0, (i < 3) ? w[(i + 1) % 4] : 0, 0);
        end
        idle_check(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
